// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus between IFU, decode stage and EXU.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   imm;
    logic [2:0]        func3;
    logic [3:0]        alu_op;
    logic [1:0]        src1_sel;
    logic [1:0]        src2_sel;
    logic              word_op;
    logic              reg_wen;
    logic              mem_ren;
    logic              mem_wen;
    logic [XLEN/8-1:0] wmask;
    logic [2:0]        jump_type;
    logic              csr_wen;
    logic [11:0]       csr_addr;
    logic              ecall;
    logic              mret;
    logic              ebreak;
    logic              illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, func3, alu_op,
               src1_sel, src2_sel, word_op, reg_wen, mem_ren, mem_wen, wmask,
               jump_type, csr_wen, csr_addr, ecall, mret, ebreak, illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, func3, alu_op,
               src1_sel, src2_sel, word_op, reg_wen, mem_ren, mem_wen, wmask,
               jump_type, csr_wen, csr_addr, ecall, mret, ebreak, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I (+Zicsr, ecall/mret/ebreak) decode stage with registered output
// and a one-entry skid buffer so backpressure does not cost throughput.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int HAS_CSR = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    decode_stage_if.slave      bus
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011,
                           OP_REG = 7'b0110011, OP_REG32 = 7'b0111011, OP_FENCE = 7'b0001111,
                           OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd3, ALU_OR = 4'd4,
                           ALU_XOR = 4'd5, ALU_SLT = 4'd6, ALU_EQ = 4'd7, ALU_SLL = 4'd8,
                           ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_SLTU = 4'd11, ALU_NONE = 4'd15;
    localparam logic [1:0] S1_RS1 = 2'd0, S1_PC = 2'd1, S1_IMM = 2'd2;
    localparam logic [1:0] S2_IMM = 2'd0, S2_FOUR = 2'd1, S2_RS2 = 2'd2, S2_ZERO = 2'd3;
    localparam logic [2:0] JT_JAL = 3'd0, JT_JALR = 3'd1, JT_BR = 3'd2, JT_SYS = 3'd3, JT_NONE = 3'd4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   imm;
        logic [2:0]        func3;
        logic [3:0]        alu_op;
        logic [1:0]        src1_sel;
        logic [1:0]        src2_sel;
        logic              word_op;
        logic              reg_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic [XLEN/8-1:0] wmask;
        logic [2:0]        jump_type;
        logic              csr_wen;
        logic [11:0]       csr_addr;
        logic              ecall;
        logic              mret;
        logic              ebreak;
        logic              illegal;
    } bundle_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [7:0]  mask8;
    logic        ill;
    bundle_t     bundle_d;
    bundle_t     out_q, skid_q;
    logic        out_valid_q, skid_full_q;
    logic        in_fire, out_load;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = XLEN'($signed(inst[31:20]));
    assign imm_s  = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));
    // Byte-lane mask grows with the access size; sd lanes drop out when XLEN=32.
    assign mask8  = (f3[1:0] == 2'd0) ? 8'h01 : (f3[1:0] == 2'd1) ? 8'h03 :
                    (f3[1:0] == 2'd2) ? 8'h0F : 8'hFF;

    // Combinational decode of the incoming instruction word into a bundle.
    always_comb begin
        bundle_d           = '0;
        ill                = 1'b0;
        bundle_d.pc        = bus.in_pc;
        bundle_d.rs1       = inst[19:15];
        bundle_d.rs2       = inst[24:20];
        bundle_d.rd        = inst[11:7];
        bundle_d.func3     = f3;
        bundle_d.csr_addr  = inst[31:20];
        bundle_d.alu_op    = ALU_NONE;
        bundle_d.jump_type = JT_NONE;
        bundle_d.src1_sel  = S1_RS1;
        bundle_d.src2_sel  = S2_IMM;
        case (opcode)
            OP_LUI: begin
                bundle_d.imm = imm_u; bundle_d.src1_sel = S1_IMM; bundle_d.src2_sel = S2_ZERO;
                bundle_d.alu_op = ALU_ADD; bundle_d.reg_wen = 1'b1;
            end
            OP_AUIPC: begin
                bundle_d.imm = imm_u; bundle_d.src1_sel = S1_PC;
                bundle_d.alu_op = ALU_ADD; bundle_d.reg_wen = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                bundle_d.imm       = (opcode == OP_JAL) ? imm_j : imm_i;
                bundle_d.jump_type = (opcode == OP_JAL) ? JT_JAL : JT_JALR;
                bundle_d.src1_sel  = S1_PC; bundle_d.src2_sel = S2_FOUR;
                bundle_d.alu_op    = ALU_ADD; bundle_d.reg_wen = 1'b1;
                ill = (opcode == OP_JALR) && (f3 != 3'b000);
            end
            OP_BRANCH: begin
                bundle_d.imm = imm_b; bundle_d.src2_sel = S2_RS2; bundle_d.jump_type = JT_BR;
                case (f3[2:1])
                    2'b00:   bundle_d.alu_op = ALU_EQ;
                    2'b10:   bundle_d.alu_op = ALU_SLT;
                    2'b11:   bundle_d.alu_op = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                bundle_d.imm = imm_i; bundle_d.alu_op = ALU_ADD;
                bundle_d.mem_ren = 1'b1; bundle_d.reg_wen = 1'b1;
                ill = (f3 == 3'b111) || (!IS64 && (f3 == 3'b011 || f3 == 3'b110));
            end
            OP_STORE: begin
                bundle_d.imm = imm_s; bundle_d.alu_op = ALU_ADD; bundle_d.mem_wen = 1'b1;
                bundle_d.wmask = mask8[XLEN/8-1:0];
                ill = f3[2] || (!IS64 && f3 == 3'b011);
            end
            OP_IMM, OP_IMM32: begin
                bundle_d.imm = imm_i; bundle_d.reg_wen = 1'b1;
                bundle_d.word_op = (opcode == OP_IMM32);
                case (f3)
                    3'b000: bundle_d.alu_op = ALU_ADD;
                    3'b010: bundle_d.alu_op = ALU_SLT;
                    3'b011: bundle_d.alu_op = ALU_SLTU;
                    3'b100: bundle_d.alu_op = ALU_XOR;
                    3'b110: bundle_d.alu_op = ALU_OR;
                    3'b111: bundle_d.alu_op = ALU_AND;
                    3'b001: begin
                        bundle_d.alu_op = ALU_SLL;
                        ill = (IS64 && opcode == OP_IMM) ? (inst[31:26] != 6'b0) : (f7 != 7'b0);
                    end
                    default: begin
                        // Right shifts: a 6-bit shamt leaves only inst[31:26] as the selector.
                        if (IS64 && opcode == OP_IMM) begin
                            if (inst[31:26] == 6'b000000)      bundle_d.alu_op = ALU_SRL;
                            else if (inst[31:26] == 6'b010000) bundle_d.alu_op = ALU_SRA;
                            else                               ill = 1'b1;
                        end else begin
                            if (f7 == 7'b0000000)      bundle_d.alu_op = ALU_SRL;
                            else if (f7 == 7'b0100000) bundle_d.alu_op = ALU_SRA;
                            else                       ill = 1'b1;
                        end
                    end
                endcase
                if (opcode == OP_IMM32 && (!IS64 || !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)))
                    ill = 1'b1;
            end
            OP_REG, OP_REG32: begin
                bundle_d.src2_sel = S2_RS2; bundle_d.reg_wen = 1'b1;
                bundle_d.word_op = (opcode == OP_REG32);
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: bundle_d.alu_op = ALU_ADD;
                        3'b001: bundle_d.alu_op = ALU_SLL;
                        3'b010: bundle_d.alu_op = ALU_SLT;
                        3'b011: bundle_d.alu_op = ALU_SLTU;
                        3'b100: bundle_d.alu_op = ALU_XOR;
                        3'b101: bundle_d.alu_op = ALU_SRL;
                        3'b110: bundle_d.alu_op = ALU_OR;
                        default: bundle_d.alu_op = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) bundle_d.alu_op = ALU_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101)     bundle_d.alu_op = ALU_SRA;
                else                                           ill = 1'b1;
                if (opcode == OP_REG32 && (!IS64 || !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)))
                    ill = 1'b1;
            end
            OP_FENCE: ill = f3[2] || f3[1];
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    if (inst == 32'h0000_0073) begin
                        bundle_d.ecall = 1'b1; bundle_d.jump_type = JT_SYS;
                        bundle_d.csr_addr = 12'h305; ill = (HAS_CSR == 0);
                    end else if (inst == 32'h3020_0073) begin
                        bundle_d.mret = 1'b1; bundle_d.jump_type = JT_SYS;
                        bundle_d.csr_addr = 12'h341; ill = (HAS_CSR == 0);
                    end else if (inst == 32'h0010_0073) begin
                        bundle_d.ebreak = 1'b1;
                    end else begin
                        ill = 1'b1;
                    end
                end else if (f3 == 3'b100 || HAS_CSR == 0) begin
                    ill = 1'b1;
                end else begin
                    // CSR ops pass rs1 (or zero-extended zimm) through the ALU as the write data.
                    bundle_d.csr_wen = 1'b1; bundle_d.reg_wen = 1'b1;
                    bundle_d.alu_op = ALU_ADD; bundle_d.src2_sel = S2_ZERO;
                    if (f3[2]) begin
                        bundle_d.imm = XLEN'(inst[19:15]); bundle_d.src1_sel = S1_IMM;
                    end
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            bundle_d.illegal = 1'b1; bundle_d.reg_wen = 1'b0; bundle_d.mem_wen = 1'b0;
            bundle_d.mem_ren = 1'b0; bundle_d.csr_wen = 1'b0; bundle_d.alu_op = ALU_NONE;
            bundle_d.jump_type = JT_NONE; bundle_d.ecall = 1'b0; bundle_d.mret = 1'b0;
            bundle_d.ebreak = 1'b0;
        end
        if (bundle_d.rd == 5'd0) bundle_d.reg_wen = 1'b0;
    end

    assign in_fire  = bus.in_valid & ~skid_full_q & ~flush;
    assign out_load = ~out_valid_q | bus.out_ready;

    // Output register plus skid entry; skid drains first so program order is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            skid_full_q      <= 1'b0;
            out_q            <= '0;
            out_q.alu_op     <= ALU_NONE;
            out_q.jump_type  <= JT_NONE;
            skid_q           <= '0;
            skid_q.alu_op    <= ALU_NONE;
            skid_q.jump_type <= JT_NONE;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (out_load) begin
            if (skid_full_q) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= bundle_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q      <= bundle_d;
            skid_full_q <= 1'b1;
        end
    end

    assign bus.in_ready  = ~skid_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.rs1       = out_q.rs1;
    assign bus.rs2       = out_q.rs2;
    assign bus.rd        = out_q.rd;
    assign bus.imm       = out_q.imm;
    assign bus.func3     = out_q.func3;
    assign bus.alu_op    = out_q.alu_op;
    assign bus.src1_sel  = out_q.src1_sel;
    assign bus.src2_sel  = out_q.src2_sel;
    assign bus.word_op   = out_q.word_op;
    assign bus.reg_wen   = out_q.reg_wen;
    assign bus.mem_ren   = out_q.mem_ren;
    assign bus.mem_wen   = out_q.mem_wen;
    assign bus.wmask     = out_q.wmask;
    assign bus.jump_type = out_q.jump_type;
    assign bus.csr_wen   = out_q.csr_wen;
    assign bus.csr_addr  = out_q.csr_addr;
    assign bus.ecall     = out_q.ecall;
    assign bus.mret      = out_q.mret;
    assign bus.ebreak    = out_q.ebreak;
    assign bus.illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one XLEN=32 and one XLEN=64 instance.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush32 = 1'b0;
    logic flush64 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if #(.XLEN(32), .PC_W(32)) bus32 ();
    decode_stage_if #(.XLEN(64), .PC_W(32)) bus64 ();

    decode_stage #(.XLEN(32), .PC_W(32), .HAS_CSR(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(bus32.slave)
    );
    decode_stage #(.XLEN(64), .PC_W(32), .HAS_CSR(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(bus64.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus32.in_valid = v;
        bus32.in_inst  = inst;
        bus32.in_pc    = pc;
    endtask

    task automatic drive64(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus64.in_valid = v;
        bus64.in_inst  = inst;
        bus64.in_pc    = pc;
    endtask

    initial begin
        drive32(1'b0, 32'h0, 32'h0);
        drive64(1'b0, 32'h0, 32'h0);
        bus32.out_ready = 1'b0;
        bus64.out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_out_valid", bus32.out_valid, 0);
        chk("reset_alu_op", bus32.alu_op, 15);
        chk("reset_jump_type", bus32.jump_type, 4);
        chk("reset_in_ready", bus32.in_ready, 1);

        // addi x1,x0,5
        drive32(1'b1, 32'h00500093, 32'h100);
        bus32.out_ready = 1'b1;
        tick();
        drive32(1'b0, 32'h0, 32'h0);
        chk("addi_valid", bus32.out_valid, 1);
        chk("addi_rd", bus32.rd, 1);
        chk("addi_imm", bus32.imm, 5);
        chk("addi_alu", bus32.alu_op, 0);
        chk("addi_src1", bus32.src1_sel, 0);
        chk("addi_src2", bus32.src2_sel, 0);
        chk("addi_wen", bus32.reg_wen, 1);
        chk("addi_pc", bus32.out_pc, 32'h100);
        tick();
        chk("addi_drained", bus32.out_valid, 0);

        // asynchronous reset while a bundle is held
        drive32(1'b1, 32'h00500093, 32'h104);
        bus32.out_ready = 1'b0;
        tick();
        drive32(1'b0, 32'h0, 32'h0);
        chk("pre_rst_valid", bus32.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus32.out_valid, 0);
        chk("async_rst_alu", bus32.alu_op, 15);
        chk("async_rst_jt", bus32.jump_type, 4);
        chk("async_rst_imm", bus32.imm, 0);
        tick();
        rst_n = 1'b1;

        // lui x2 then sw x1,8(x2) under backpressure
        drive32(1'b1, 32'h12345137, 32'h200);
        tick();
        chk("lui_valid", bus32.out_valid, 1);
        chk("lui_rd", bus32.rd, 2);
        chk("lui_imm", bus32.imm, 32'h12345000);
        chk("lui_src1", bus32.src1_sel, 2);
        chk("lui_src2", bus32.src2_sel, 3);
        chk("lui_in_ready", bus32.in_ready, 1);
        drive32(1'b1, 32'h00112423, 32'h204);
        tick();
        drive32(1'b0, 32'h0, 32'h0);
        chk("skid_in_ready", bus32.in_ready, 0);
        chk("held_pc", bus32.out_pc, 32'h200);
        chk("held_imm", bus32.imm, 32'h12345000);
        tick();
        chk("skid2_in_ready", bus32.in_ready, 0);
        chk("held2_pc", bus32.out_pc, 32'h200);
        chk("held2_valid", bus32.out_valid, 1);
        bus32.out_ready = 1'b1;
        tick();
        chk("sw_valid", bus32.out_valid, 1);
        chk("sw_pc", bus32.out_pc, 32'h204);
        chk("sw_imm", bus32.imm, 8);
        chk("sw_mem_wen", bus32.mem_wen, 1);
        chk("sw_wmask", bus32.wmask, 4'hF);
        chk("sw_reg_wen", bus32.reg_wen, 0);
        chk("sw_in_ready", bus32.in_ready, 1);
        tick();
        chk("sw_no_dup", bus32.out_valid, 0);

        // beq x0,x0,-4 then flush with a concurrent handshake
        drive32(1'b1, 32'hFE000EE3, 32'h300);
        tick();
        drive32(1'b0, 32'h0, 32'h0);
        chk("beq_valid", bus32.out_valid, 1);
        chk("beq_imm", bus32.imm, 32'hFFFFFFFC);
        chk("beq_jt", bus32.jump_type, 2);
        chk("beq_alu", bus32.alu_op, 7);
        chk("beq_src2", bus32.src2_sel, 2);
        chk("beq_wen", bus32.reg_wen, 0);
        flush32 = 1'b1;
        bus32.out_ready = 1'b0;
        drive32(1'b1, 32'h00500093, 32'h304);
        tick();
        flush32 = 1'b0;
        drive32(1'b0, 32'h0, 32'h0);
        chk("flush_valid", bus32.out_valid, 0);
        chk("flush_in_ready", bus32.in_ready, 1);
        tick();
        chk("flush_discard", bus32.out_valid, 0);

        // back-to-back system / illegal / RV64-only encodings on XLEN=32
        bus32.out_ready = 1'b1;
        drive32(1'b1, 32'h00100073, 32'h400);
        tick();
        chk("ebreak_flag", bus32.ebreak, 1);
        chk("ebreak_wen", bus32.reg_wen, 0);
        chk("ebreak_illegal", bus32.illegal, 0);
        drive32(1'b1, 32'h00000000, 32'h404);
        tick();
        chk("zero_valid", bus32.out_valid, 1);
        chk("zero_illegal", bus32.illegal, 1);
        chk("zero_wen", bus32.reg_wen, 0);
        chk("zero_mem_wen", bus32.mem_wen, 0);
        chk("zero_mem_ren", bus32.mem_ren, 0);
        chk("zero_csr_wen", bus32.csr_wen, 0);
        chk("zero_alu", bus32.alu_op, 15);
        drive32(1'b1, 32'h00000073, 32'h408);
        tick();
        chk("ecall_flag", bus32.ecall, 1);
        chk("ecall_jt", bus32.jump_type, 3);
        chk("ecall_csr", bus32.csr_addr, 12'h305);
        drive32(1'b1, 32'h30200073, 32'h40C);
        tick();
        chk("mret_flag", bus32.mret, 1);
        chk("mret_csr", bus32.csr_addr, 12'h341);
        drive32(1'b1, 32'h300312F3, 32'h410);
        tick();
        chk("csrrw_csr_wen", bus32.csr_wen, 1);
        chk("csrrw_wen", bus32.reg_wen, 1);
        chk("csrrw_addr", bus32.csr_addr, 12'h300);
        drive32(1'b1, 32'h4200D093, 32'h414);
        tick();
        chk("srai32_illegal", bus32.illegal, 1);
        drive32(1'b1, 32'h00003083, 32'h418);
        tick();
        chk("ld32_illegal", bus32.illegal, 1);
        drive32(1'b1, 32'h0010109B, 32'h41C);
        tick();
        chk("slliw32_illegal", bus32.illegal, 1);
        drive32(1'b0, 32'h0, 32'h0);

        // XLEN=64 instance
        drive64(1'b1, 32'h0010109B, 32'h500);
        tick();
        chk("slliw64_valid", bus64.out_valid, 1);
        chk("slliw64_word", bus64.word_op, 1);
        chk("slliw64_alu", bus64.alu_op, 8);
        chk("slliw64_illegal", bus64.illegal, 0);
        drive64(1'b1, 32'h4200D093, 32'h504);
        tick();
        chk("srai64_alu", bus64.alu_op, 10);
        chk("srai64_imm", bus64.imm, 64'h420);
        chk("srai64_illegal", bus64.illegal, 0);
        drive64(1'b1, 32'h00003083, 32'h508);
        tick();
        chk("ld64_illegal", bus64.illegal, 0);
        chk("ld64_mem_ren", bus64.mem_ren, 1);
        drive64(1'b1, 32'h00113023, 32'h50C);
        tick();
        chk("sd64_wmask", bus64.wmask, 8'hFF);
        chk("sd64_mem_wen", bus64.mem_wen, 1);
        drive64(1'b1, 32'hFE000EE3, 32'h510);
        tick();
        drive64(1'b0, 32'h0, 32'h0);
        chk("beq64_imm", bus64.imm, 64'hFFFFFFFFFFFFFFFC);
        tick();
        chk("x64_drained", bus64.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32I/RV64I instruction decode stage for the pipelined NPC.
- Sits between IFU and EXU; uses valid/ready handshakes on both sides.
- Decodes the full base ISA plus Zicsr, ecall, mret and ebreak; flags illegal encodings.
- Reports ebreak as a flag instead of ending simulation itself.
- A one-entry skid buffer keeps throughput at one instruction per cycle under downstream backpressure.

Parameters:
- XLEN, 32, datapath width; 32 or 64. 64 enables OP-IMM-32 and OP-32 plus 6-bit shift amounts.
- PC_W, 32, PC width.
- HAS_CSR, 1, if 0 then all SYSTEM opcodes except ebreak are illegal.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all buffered/held instructions (branch redirect)
- in_valid  in  1  IFU has an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts
- out_pc  out  PC_W  PC of bundle
- rs1, rs2, rd  out  5 each  register indices
- imm  out  XLEN  sign-extended immediate
- func3  out  3  inst[14:12]
- alu_op  out  4  0 add, 1 sub, 3 and, 4 or, 5 xor, 6 slt, 7 eq, 8 sll, 9 srl, 10 sra, 11 sltu, 15 none
- src1_sel  out  2  0 rs1, 1 pc, 2 imm, 3 zero
- src2_sel  out  2  0 imm, 1 const 4, 2 rs2, 3 zero
- word_op  out  1  RV64 *W op; EXU sign-extends bit 31
- reg_wen, mem_ren, mem_wen  out  1 each  write-back, load, store
- wmask  out  XLEN/8  store byte mask: sb 0x1, sh 0x3, sw 0xF, sd 0xFF
- jump_type  out  3  0 jal, 1 jalr, 2 branch, 3 ecall/mret, 4 none
- csr_wen  out  1  CSR instruction
- csr_addr  out  12  inst[31:20]; 0x305 for ecall, 0x341 for mret
- ecall, mret, ebreak, illegal  out  1 each  system/exception flags

Behaviour:
- Decode is combinational on in_inst. Results are captured into the output register on the in handshake (in_valid & in_ready).
- Latency is one cycle: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Output register: loads when it is empty, or when out_valid & out_ready in the same cycle.
- Skid buffer:
  - Captures the incoming bundle when in_valid & in_ready while the output register holds and out_ready=0.
  - in_ready = ~skid_full.
  - When the output is consumed, the skid entry moves into the output register first. The order of instructions is preserved.
- Output stability: while out_valid=1 and out_ready=0, every out_* field is held stable.
- Flush: out_valid and skid_full clear on the next edge. An in handshake in the same cycle is discarded. Flush has priority over all other events.
- Reset: asynchronously forces out_valid=0, skid_full=0, and every registered field to 0, except:
  - alu_op=15
  - jump_type=4
- Immediates, sign-extended from inst[31] to XLEN:
  - I, S, B and J formats: standard RISC-V immediates.
  - U format: {inst[31:12], 12'b0}.
- Shifts:
  - XLEN=32: slli/srli/srai with inst[25]=1 are illegal.
  - XLEN=64: shamt is inst[25:20], and inst[31:26] selects srl/sra.
  - *W shift forms use a 5-bit shamt.
- Loads: ld and lwu are legal only when XLEN=64; otherwise illegal.
- Operand selects and ALU ops:
  - lui: src1=imm, src2=zero, add.
  - auipc: src1=pc, src2=imm, add.
  - jal/jalr: src1=pc, src2=4, add.
  - Branches: src1=rs1, src2=rs2; beq/bne use eq, blt/bge use slt, bltu/bgeu use sltu.
  - Loads/stores: src1=rs1, src2=imm, add.
- Write enables:
  - reg_wen=0 for stores, branches, ecall, mret, ebreak, fence and illegal.
  - reg_wen=0 when rd=0.
- Illegal instructions: unknown opcode, funct7 not in the legal set for OP/OP-32, or inst[1:0]≠11.
  - Output: illegal=1, reg_wen=0, mem_wen=0, mem_ren=0, csr_wen=0, alu_op=15.
  - The bundle still flows through the stage.
- fence/fence.i decode as no-ops: alu_op=15, no enables set.

Test Plan:
- Reset while out_valid=1 -> out_valid=0, alu_op=15, jump_type=4 immediately, without waiting for a clock edge.
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: rd=1, imm=5, alu_op=0, src1_sel=0, src2_sel=0, reg_wen=1.
- 0x12345137 (lui x2) then 0x00112423 (sw x1,8(x2)) with out_ready=0 for 2 cycles:
  - First cycle: the lui bundle is held and the sw goes to the skid buffer.
  - Second cycle: in_ready=0.
  - After release: lui, then sw (imm=8, mem_wen=1, wmask=0xF, reg_wen=0), with no loss or duplication.
- 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, jump_type=2, alu_op=7, src2_sel=2. Asserting flush the same cycle out_valid rises -> out_valid=0 next cycle.
- 0x00100073 -> ebreak=1, reg_wen=0. 0x00000000 -> illegal=1 with all enables 0.
- XLEN=64: 0x0010109B (slliw x1,x1,1) -> word_op=1, alu_op=8. With XLEN=32 the same word gives illegal=1.
